// File: rtl/trigger_sequencer_pkg.sv
// Shared encodings and default widths for the two-stage trigger sequencer.
// State encodings are also the readback values seen by the register layer.
package trigger_sequencer_pkg;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned FAIL_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_A = 3'd1,
    WINDOW = 3'd2,
    FIRE   = 3'd3,
    DONE   = 3'd4
  } seq_state_e;
endpackage

// File: rtl/trigger_sequencer_if.sv
// Control/status bundle between the edge triggers, register layer and the sequencer.
// The master side is whoever drives arm, triggers and windows. The slave side is the sequencer.
interface trigger_sequencer_if
  import trigger_sequencer_pkg::*;
#(
  parameter int pCNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int pFAIL_WIDTH = FAIL_WIDTH_DEF
);
  logic                   armed_and_ready;
  logic                   enable;
  logic                   stage_b_en;
  logic                   trig_a;
  logic                   trig_b;
  logic [pCNT_WIDTH-1:0]  window_min;
  logic [pCNT_WIDTH-1:0]  window_max;
  logic                   trigger;
  logic                   busy;
  logic [2:0]             state;
  logic [pFAIL_WIDTH-1:0] fail_count;

  modport master (
    output armed_and_ready, enable, stage_b_en, trig_a, trig_b, window_min, window_max,
    input  trigger, busy, state, fail_count
  );

  modport slave (
    input  armed_and_ready, enable, stage_b_en, trig_a, trig_b, window_min, window_max,
    output trigger, busy, state, fail_count
  );
endinterface

// File: rtl/trig_window_cnt.sv
// A-to-B delay counter. It loads to 1 on stage A and increments once per cycle in the window.
// It classifies the current delay against the programmed bounds.
module trig_window_cnt #(
  parameter int pCNT_WIDTH = 16
) (
  input  logic                  clk_adc,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  inc,
  input  logic [pCNT_WIDTH-1:0] window_min,
  input  logic [pCNT_WIDTH-1:0] window_max,
  output logic                  in_window,
  output logic                  too_early,
  output logic                  timeout
);
  logic [pCNT_WIDTH-1:0] count;
  logic [pCNT_WIDTH-1:0] min_eff;

  always_ff @(posedge clk_adc) begin
    if (reset)     count <= '0;
    else if (load) count <= pCNT_WIDTH'(1);
    else if (inc)  count <= count + pCNT_WIDTH'(1);
  end

  // A zero minimum means "B in the very next cycle". Using >= for the timeout also catches a max lowered mid-window.
  always_comb begin
    min_eff   = (window_min == '0) ? pCNT_WIDTH'(1) : window_min;
    too_early = (count < min_eff);
    in_window = !too_early && (count <= window_max);
    timeout   = (count >= window_max);
  end
endmodule

// File: rtl/trigger_sequencer.sv
// Two-stage trigger sequencer. It fires one registered trigger when B follows A within the window.
// It fires at most once per arm cycle and counts failed sequences, saturating.
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int pCNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int pFAIL_WIDTH = FAIL_WIDTH_DEF
) (
  input logic                 clk_adc,
  input logic                 reset,
  trigger_sequencer_if.slave  bus
);
  seq_state_e             state_q, state_d;
  logic                   trigger_q, busy_q;
  logic [pFAIL_WIDTH-1:0] fail_q;
  logic                   cnt_load, cnt_inc, fail_inc, fail_clr;
  logic                   in_window, too_early, timeout;
  logic                   go, win_fail;

  assign go       = bus.armed_and_ready && bus.enable;
  assign win_fail = bus.trig_b ? (too_early || !in_window) : timeout;

  trig_window_cnt #(.pCNT_WIDTH(pCNT_WIDTH)) u_cnt (
    .clk_adc    (clk_adc),
    .reset      (reset),
    .load       (cnt_load),
    .inc        (cnt_inc),
    .window_min (bus.window_min),
    .window_max (bus.window_max),
    .in_window  (in_window),
    .too_early  (too_early),
    .timeout    (timeout)
  );

  always_ff @(posedge clk_adc) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    fail_inc = 1'b0;
    fail_clr = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d  = WAIT_A;
        fail_clr = 1'b1;
      end
      WAIT_A: if (bus.trig_a) begin
        if (bus.stage_b_en) begin
          state_d  = WINDOW;
          cnt_load = 1'b1;
        end else begin
          state_d  = FIRE;
        end
      end
      WINDOW: begin
        if (bus.trig_b && in_window) begin
          state_d = FIRE;
        end else if (win_fail) begin
          fail_inc = 1'b1;
          if (bus.trig_a) cnt_load = 1'b1;
          else            state_d  = WAIT_A;
        end else if (bus.trig_a) begin
          cnt_load = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FIRE:    state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Disarm/disable wins over everything, including a pending fire; counters hold.
    if (!go) begin
      state_d  = IDLE;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      fail_inc = 1'b0;
      fail_clr = 1'b0;
    end
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= '0;
    end else begin
      trigger_q <= (state_d == FIRE);
      busy_q    <= (state_d != IDLE);
      if (fail_clr)                      fail_q <= '0;
      else if (fail_inc && fail_q != '1) fail_q <= fail_q + pFAIL_WIDTH'(1);
    end
  end

  assign bus.trigger    = trigger_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;
  assign bus.fail_count = fail_q;
endmodule
